gcd_req_arbiter: RTL and testbench

Shares one iterative gcd unit (val/rdy request and response channels) among NREQ independent requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Each result is returned only to the requester that issued it, tagged with that requester's id.
- Sits between the client blocks in top-level integration and the single gcd instance.
- Also reports busy status and the latency of the most recent completed transaction.

---
 rtl/gcd_arb_pkg.sv | 21 ++
 rtl/gcd_req_arbiter_rr_pick.sv | 34 +++
 rtl/gcd_req_arbiter.sv | 125 ++++++++++++
 tb/tb_gcd_req_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and sizing helpers for the gcd request arbiter.
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } state_t;

    localparam int DEF_MSG_W  = 32;
    localparam int DEF_RESP_W = 16;
    localparam int DEF_LAT_W  = 16;
    localparam int DEF_OPND_W = DEF_MSG_W / 2;

    // A single requester still needs a 1-bit id.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gcd_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request at or after the pointer, wrapping.
module rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = calc_id_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    int w_pos;

    // Scanning from the farthest offset back to the pointer lets the nearest hit win.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_pos]) begin
                o_grant        = '0;
                o_grant[w_pos] = 1'b1;
                o_idx          = ID_W'(w_pos);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_req_arbiter.sv
// Shares one val/rdy gcd unit among NREQ requesters, one transaction at a time,
// returning each result to its issuer and tracking the last transaction latency.
module gcd_req_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int  NREQ   = 4,
    parameter int  MSG_W  = DEF_MSG_W,
    parameter int  RESP_W = DEF_RESP_W,
    parameter int  LAT_W  = DEF_LAT_W,
    localparam int ID_W   = calc_id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_val,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*MSG_W-1:0] req_msg,
    output logic [NREQ-1:0]       resp_val,
    input  logic [NREQ-1:0]       resp_rdy,
    output logic [RESP_W-1:0]     resp_msg,
    output logic [ID_W-1:0]       resp_id,
    output logic                  gcd_req_val,
    input  logic                  gcd_req_rdy,
    output logic [MSG_W-1:0]      gcd_req_msg,
    input  logic                  gcd_resp_val,
    output logic                  gcd_resp_rdy,
    input  logic [RESP_W-1:0]     gcd_resp_msg,
    output logic                  busy,
    output logic [LAT_W-1:0]      last_latency
);

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_owner;
    logic [MSG_W-1:0]    r_msg;
    logic [RESP_W-1:0]   r_result;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [LAT_W-1:0]    r_last_lat;

    logic [NREQ-1:0]     w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_idle;
    logic                w_resp_fire;
    logic                w_lat_max;
    logic [ID_W-1:0]     w_next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .i_req   (req_val),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_idle      = (r_state == IDLE);
    assign w_resp_fire = (r_state == RETURN) && resp_rdy[r_owner];
    assign w_lat_max   = (r_lat_cnt == {LAT_W{1'b1}});
    assign w_next_ptr  = (r_owner == ID_W'(NREQ - 1)) ? '0 : ID_W'(r_owner + 1'b1);

    // Grants are withheld while reset is asserted even though the state already reads IDLE.
    assign req_rdy = (w_idle && reset) ? w_grant : '0;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp_val
            assign resp_val[gi] = (r_state == RETURN) && (r_owner == ID_W'(gi));
        end
    endgenerate

    assign resp_msg     = r_result;
    assign resp_id      = r_owner;
    assign gcd_req_val  = (r_state == ISSUE);
    assign gcd_req_msg  = r_msg;
    assign gcd_resp_rdy = (r_state == WAIT);
    assign busy         = !w_idle;
    assign last_latency = r_last_lat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_msg      <= '0;
            r_result   <= '0;
            r_lat_cnt  <= '0;
            r_last_lat <= '0;
        end else begin
            if (!w_idle && !w_lat_max) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_idx;
                        r_msg     <= req_msg[w_idx*MSG_W +: MSG_W];
                        r_lat_cnt <= LAT_W'(1);
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gcd_req_rdy) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (gcd_resp_val) begin
                        r_result <= gcd_resp_msg;
                        r_state  <= RETURN;
                    end
                end
                RETURN: begin
                    if (w_resp_fire) begin
                        r_last_lat <= r_lat_cnt;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_req_arbiter.sv
// Directed bench for gcd_req_arbiter; the bench itself plays the gcd unit and the clients.
module tb_gcd_req_arbiter;

    localparam int NREQ   = 4;
    localparam int MSG_W  = 32;
    localparam int RESP_W = 16;
    localparam int LAT_W  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_val;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*MSG_W-1:0] req_msg;
    logic [NREQ-1:0]       resp_val;
    logic [NREQ-1:0]       resp_rdy;
    logic [RESP_W-1:0]     resp_msg;
    logic [1:0]            resp_id;
    logic                  gcd_req_val;
    logic                  gcd_req_rdy;
    logic [MSG_W-1:0]      gcd_req_msg;
    logic                  gcd_resp_val;
    logic                  gcd_resp_rdy;
    logic [RESP_W-1:0]     gcd_resp_msg;
    logic                  busy;
    logic [LAT_W-1:0]      last_latency;

    int checks = 0;
    int errors = 0;

    gcd_req_arbiter #(
        .NREQ   (NREQ),
        .MSG_W  (MSG_W),
        .RESP_W (RESP_W),
        .LAT_W  (LAT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .resp_id      (resp_id),
        .gcd_req_val  (gcd_req_val),
        .gcd_req_rdy  (gcd_req_rdy),
        .gcd_req_msg  (gcd_req_msg),
        .gcd_resp_val (gcd_resp_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .gcd_resp_msg (gcd_resp_msg),
        .busy         (busy),
        .last_latency (last_latency)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic set_req(input int id, input logic [31:0] msg);
        req_msg[id*MSG_W +: MSG_W] = msg;
        req_val[id] = 1'b1;
    endtask

    // One full transaction for the expected grantee; the gcd side is played from here.
    task automatic do_txn(input string tag, input int exp_id, input logic [31:0] exp_msg,
                          input bit drop, input int gstall, input int compute, input int rstall,
                          input logic [15:0] exp_res, input int exp_lat);
        logic [3:0] oh;
        int         n;
        bit         ok;
        oh = 4'b0001 << exp_id;
        n  = 0;
        #1;
        while (req_rdy === 4'b0000 && n < 20) begin
            step();
            #1;
            n++;
        end
        chk({tag, ".grant"}, 64'(req_rdy), 64'(oh));
        if (req_rdy !== oh) return;
        $display("txn %s: granted requester %0d msg=%h", tag, exp_id, exp_msg);
        step();
        if (drop) req_val[exp_id] = 1'b0;
        #1;
        chk({tag, ".issue_val"}, 64'(gcd_req_val), 64'(1));
        chk({tag, ".issue_msg"}, 64'(gcd_req_msg), 64'(exp_msg));
        chk({tag, ".issue_rdy0"}, 64'(req_rdy), 64'(0));
        gcd_req_rdy = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < gstall; i++) begin
            step();
            if (gcd_req_val !== 1'b1 || gcd_req_msg !== exp_msg || busy !== 1'b1) ok = 1'b0;
        end
        chk({tag, ".issue_hold"}, 64'(ok), 64'(1));
        gcd_req_rdy = 1'b1;
        step();
        gcd_req_rdy = 1'b0;
        chk({tag, ".wait_rdy"}, 64'(gcd_resp_rdy), 64'(1));
        chk({tag, ".wait_reqval"}, 64'(gcd_req_val), 64'(0));
        for (int i = 0; i < compute; i++) step();
        gcd_resp_val = 1'b1;
        gcd_resp_msg = gcd16(exp_msg[31:16], exp_msg[15:0]);
        step();
        gcd_resp_val = 1'b0;
        gcd_resp_msg = 16'hDEAD;
        resp_rdy = ~oh;
        ok = 1'b1;
        for (int i = 0; i < rstall; i++) begin
            step();
            if (resp_val !== oh || resp_msg !== exp_res || req_rdy !== 4'b0000) ok = 1'b0;
        end
        chk({tag, ".ret_hold"}, 64'(ok), 64'(1));
        #1;
        chk({tag, ".resp_val"}, 64'(resp_val), 64'(oh));
        chk({tag, ".resp_msg"}, 64'(resp_msg), 64'(exp_res));
        chk({tag, ".resp_id"}, 64'(resp_id), 64'(exp_id));
        chk({tag, ".ret_rdy0"}, 64'(req_rdy), 64'(0));
        resp_rdy = oh;
        step();
        resp_rdy = 4'b0000;
        chk({tag, ".done_val"}, 64'(resp_val), 64'(0));
        chk({tag, ".latency"}, 64'(last_latency), 64'(exp_lat));
        chk({tag, ".idle"}, 64'(busy), 64'(0));
        $display("txn %s: id=%0d result=%0d latency=%0d", tag, resp_id, resp_msg, last_latency);
    endtask

    initial begin
        reset        = 1'b0;
        req_val      = '0;
        req_msg      = '0;
        resp_rdy     = '0;
        gcd_req_rdy  = 1'b0;
        gcd_resp_val = 1'b0;
        gcd_resp_msg = '0;

        // Requesters 0 and 2 already asserting during reset.
        set_req(0, 32'h000C_0008);
        set_req(2, 32'h0015_000E);
        step();
        step();
        chk("rst.req_rdy", 64'(req_rdy), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.resp_val", 64'(resp_val), 64'(0));
        chk("rst.gcd_req_val", 64'(gcd_req_val), 64'(0));
        chk("rst.gcd_resp_rdy", 64'(gcd_resp_rdy), 64'(0));
        chk("rst.last_latency", 64'(last_latency), 64'(0));
        chk("rst.resp_msg", 64'(resp_msg), 64'(0));
        chk("rst.resp_id", 64'(resp_id), 64'(0));
        chk("rst.gcd_req_msg", 64'(gcd_req_msg), 64'(0));
        $display("reset: outputs checked");
        reset = 1'b1;

        do_txn("cont_a", 0, 32'h000C_0008, 1'b0, 0, 0, 0, 16'd4, 3);
        do_txn("cont_b", 2, 32'h0015_000E, 1'b0, 0, 0, 0, 16'd7, 3);
        do_txn("cont_c", 0, 32'h000C_0008, 1'b0, 0, 0, 0, 16'd4, 3);
        do_txn("cont_d", 2, 32'h0015_000E, 1'b1, 0, 0, 0, 16'd7, 3);
        req_val = '0;

        set_req(1, 32'h000F_0005);
        do_txn("single", 1, 32'h000F_0005, 1'b1, 0, 2, 0, 16'd5, 5);

        set_req(3, 32'h0023_0015);
        do_txn("bp_req", 3, 32'h0023_0015, 1'b1, 5, 0, 0, 16'd7, 8);

        set_req(2, 32'h0009_0006);
        do_txn("bp_resp", 2, 32'h0009_0006, 1'b1, 0, 0, 10, 16'd3, 13);

        set_req(0, 32'h0007_0007);
        do_txn("sat", 0, 32'h0007_0007, 1'b1, 20, 0, 0, 16'd7, 15);

        set_req(1, 32'h0064_004B);
        do_txn("post_sat", 1, 32'h0064_004B, 1'b1, 0, 0, 0, 16'd25, 3);

        // Pointer now sits at 2; abort a transaction from requester 3 while in WAIT.
        set_req(3, 32'h0011_0011);
        #1;
        chk("rmid.grant", 64'(req_rdy), 64'(4'b1000));
        step();
        req_val[3]  = 1'b0;
        gcd_req_rdy = 1'b1;
        step();
        gcd_req_rdy = 1'b0;
        chk("rmid.in_wait", 64'(gcd_resp_rdy), 64'(1));
        reset = 1'b0;
        #1;
        chk("rmid.busy", 64'(busy), 64'(0));
        chk("rmid.gcd_resp_rdy", 64'(gcd_resp_rdy), 64'(0));
        chk("rmid.gcd_req_val", 64'(gcd_req_val), 64'(0));
        chk("rmid.resp_val", 64'(resp_val), 64'(0));
        chk("rmid.last_latency", 64'(last_latency), 64'(0));
        chk("rmid.resp_msg", 64'(resp_msg), 64'(0));
        chk("rmid.gcd_req_msg", 64'(gcd_req_msg), 64'(0));
        step();
        step();
        chk("rmid.req_rdy", 64'(req_rdy), 64'(0));
        $display("reset mid-WAIT: outputs checked");
        reset = 1'b1;

        // With the pointer back at 0, requester 1 must win over 3.
        set_req(1, 32'h0030_0012);
        set_req(3, 32'h0011_0011);
        do_txn("after_rst", 1, 32'h0030_0012, 1'b1, 0, 0, 0, 16'd6, 3);
        do_txn("after_rst3", 3, 32'h0011_0011, 1'b1, 0, 0, 0, 16'd17, 3);
        req_val = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
